// File: rtl/adc_frame_aligner.sv
// adc_frame_aligner: per-channel frame-word bitslip alignment with lock supervision
module adc_frame_aligner #(
  parameter int CH = 8,
  parameter int S = 8,
  parameter logic [7:0] FRAME_PATTERN = 8'hF0,
  parameter int MATCH_COUNT = 16,
  parameter int LOSS_COUNT = 4,
  parameter int SETTLE = 4
) (
  input  logic            ref_clk,
  input  logic            ref_rst,
  input  logic            enable,
  input  logic            realign,
  input  logic            word_valid,
  input  logic [CH*S-1:0] frame_word,
  input  logic [CH*S-1:0] data_word,
  output logic [CH-1:0]   bitslip,
  output logic [CH-1:0]   aligned,
  output logic [CH-1:0]   align_err,
  output logic            all_aligned,
  output logic [CH*S-1:0] data_out,
  output logic            data_out_valid
);
  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int LW = $clog2(LOSS_COUNT + 1);
  localparam int SW = $clog2(S + 1);
  localparam int TW = $clog2(SETTLE + 1);
  localparam logic [S-1:0] FP = FRAME_PATTERN[S-1:0];
  typedef enum logic [2:0] {IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL} state_t;
  logic [CH-1:0] slip_n, lock_n, err_n;
  for (genvar c = 0; c < CH; c++) begin : ch
    state_t st, nx;
    logic [MW-1:0] mc, mn;
    logic [LW-1:0] lc, ln;
    logic [SW-1:0] sc, sn;
    logic [TW-1:0] tc, tn;
    logic hit;
    assign hit = frame_word[c*S +: S] == FP;
    always_ff @(posedge ref_clk or posedge ref_rst)
      if (ref_rst) begin
        st <= IDLE;
        mc <= '0;
        lc <= '0;
        sc <= '0;
        tc <= '0;
      end else begin
        st <= nx;
        mc <= mn;
        lc <= ln;
        sc <= sn;
        tc <= tn;
      end
    always_comb begin
      nx = st;
      mn = mc;
      ln = lc;
      sn = sc;
      tn = tc;
      if (!enable || realign || st == IDLE) begin
        nx = enable ? CHECK : IDLE;
        mn = '0;
        ln = '0;
        sn = '0;
        tn = '0;
      end else
        case (st)
          CHECK: if (word_valid) begin
            mn = hit ? mc + MW'(1) : '0;
            if (hit && mn == MW'(MATCH_COUNT)) nx = LOCKED;
            else if (!hit) nx = sc == SW'(S - 1) ? FAIL : SLIP;
          end
          SLIP: begin
            sn = sc + SW'(1);
            tn = TW'(SETTLE);
            nx = WAIT;
          end
          WAIT: begin
            tn = tc - TW'(1);
            if (tc <= TW'(1)) begin
              nx = CHECK;
              tn = '0;
              mn = '0;
            end
          end
          LOCKED: if (word_valid) begin
            ln = hit ? '0 : lc + LW'(1);
            if (ln == LW'(LOSS_COUNT)) begin
              nx = CHECK;
              ln = '0;
              sn = '0;
              mn = '0;
            end
          end
          FAIL: nx = FAIL;
          default: nx = IDLE;
        endcase
    end
    assign slip_n[c] = nx == SLIP;
    assign lock_n[c] = nx == LOCKED;
    assign err_n[c] = nx == FAIL;
  end
  // status flags are registered from next state so they line up with the FSM
  always_ff @(posedge ref_clk or posedge ref_rst)
    if (ref_rst) begin
      bitslip <= '0;
      aligned <= '0;
      align_err <= '0;
      all_aligned <= 1'b0;
      data_out <= '0;
      data_out_valid <= 1'b0;
    end else begin
      bitslip <= slip_n;
      aligned <= lock_n;
      align_err <= err_n;
      all_aligned <= &lock_n;
      data_out_valid <= word_valid & all_aligned;
      if (word_valid) data_out <= data_word;
    end
endmodule

// File: tb/tb_adc_frame_aligner.sv
// tb_adc_frame_aligner: lane emulator with bitslip rotation, behavioural model, vector table
module tb_adc_frame_aligner;
  localparam int CH = 8, S = 8, MATCH = 16, LOSS = 4, SETTLE = 4;
  localparam logic [S-1:0] FP = 8'hF0;
  logic ref_clk = 0, ref_rst = 1, en = 0, rl = 0, wv = 0;
  logic [CH*S-1:0] fw = '0, dw = '0, data_out;
  logic [CH-1:0] bitslip, aligned, align_err, prev_bs = '0;
  logic all_aligned, data_out_valid;
  adc_frame_aligner #(.CH(CH), .S(S), .FRAME_PATTERN(FP), .MATCH_COUNT(MATCH),
    .LOSS_COUNT(LOSS), .SETTLE(SETTLE)) dut (
    .ref_clk(ref_clk), .ref_rst(ref_rst), .enable(en), .realign(rl), .word_valid(wv),
    .frame_word(fw), .data_word(dw), .bitslip(bitslip), .aligned(aligned),
    .align_err(align_err), .all_aligned(all_aligned), .data_out(data_out),
    .data_out_valid(data_out_valid));
  always #5 ref_clk = ~ref_clk;
  int n_chk = 0, n_fail = 0, cyc = 0, gap_pct = 0, first_al0 = -1;
  bit spc_on = 0;
  int off[CH], nslip[CH], last[CH];
  bit never[CH];
  int run[CH], bad[CH], slips[CH], hold[CH];
  bit on[CH], lk[CH], fl[CH], sp[CH];
  logic [CH-1:0] e_bs = '0, e_al = '0, e_er = '0;
  logic e_all = 0, e_dv = 0;
  logic [CH*S-1:0] e_do = '0;
  typedef struct {bit wv; bit hit; logic [CH-1:0] al; logic [CH-1:0] bs;} vec_t;
  vec_t tbl[12];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [S-1:0] rot(input logic [S-1:0] p, input int k);
    return k == 0 ? p : (p << k) | (p >> (S - k));
  endfunction
  task automatic model_clear(input int c);
    run[c] = 0; bad[c] = 0; slips[c] = 0; hold[c] = 0;
    lk[c] = 0; fl[c] = 0; sp[c] = 0;
  endtask
  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      model_clear(c);
      on[c] = 0;
    end
    e_bs = '0; e_al = '0; e_er = '0; e_all = 0; e_dv = 0; e_do = '0;
  endtask
  // channel progress expressed as slips taken, match run, loss run and settle time left
  task automatic model_step();
    bit hit;
    e_dv = wv & e_all;
    if (wv) e_do = dw;
    for (int c = 0; c < CH; c++) begin
      hit = fw[c*S +: S] == FP;
      if (!en) begin
        model_clear(c);
        on[c] = 0;
      end else if (rl || !on[c]) begin
        model_clear(c);
        on[c] = 1;
      end else if (fl[c]) begin
      end else if (sp[c]) begin
        sp[c] = 0;
        slips[c]++;
        hold[c] = SETTLE;
      end else if (hold[c] > 0) hold[c]--;
      else if (lk[c]) begin
        if (wv) begin
          bad[c] = hit ? 0 : bad[c] + 1;
          if (bad[c] == LOSS) begin
            lk[c] = 0; bad[c] = 0; slips[c] = 0; run[c] = 0;
          end
        end
      end else if (wv) begin
        if (hit) begin
          run[c]++;
          if (run[c] == MATCH) lk[c] = 1;
        end else begin
          run[c] = 0;
          if (slips[c] == S - 1) fl[c] = 1;
          else sp[c] = 1;
        end
      end
      e_bs[c] = sp[c];
      e_al[c] = lk[c];
      e_er[c] = fl[c];
    end
    e_all = &e_al;
  endtask
  task automatic tick();
    model_step();
    @(posedge ref_clk);
    #1;
    cyc++;
    chk("bitslip", bitslip, e_bs);
    chk("aligned", aligned, e_al);
    chk("align_err", align_err, e_er);
    chk("all_aligned", all_aligned, e_all);
    chk("data_out_valid", data_out_valid, e_dv);
    chk("data_out", data_out, e_do);
    chk("bitslip_consecutive", bitslip & prev_bs, '0);
    prev_bs = bitslip;
    @(negedge ref_clk);
  endtask
  task automatic lane_tick();
    logic [S-1:0] w;
    for (int c = 0; c < CH; c++) begin
      w = S'($urandom);
      if (w == FP) w = ~FP;
      fw[c*S +: S] = never[c] ? w : rot(FP, off[c]);
    end
    dw = {$urandom, $urandom};
    wv = $urandom_range(0, 99) >= gap_pct;
    tick();
    for (int c = 0; c < CH; c++)
      if (bitslip[c]) begin
        off[c] = (off[c] + S - 1) % S;
        nslip[c]++;
        if (spc_on && last[c] >= 0) chk("slip_spacing", 32'(cyc - last[c] >= SETTLE + 2), 1);
        last[c] = cyc;
      end
  endtask
  task automatic clear_counts();
    for (int c = 0; c < CH; c++) begin
      nslip[c] = 0;
      last[c] = -1;
    end
  endtask
  task automatic pulse_realign();
    rl = 1;
    lane_tick();
    rl = 0;
  endtask
  task automatic outputs_zero(input string nm);
    chk({nm, "_bitslip"}, bitslip, '0);
    chk({nm, "_aligned"}, aligned, '0);
    chk({nm, "_align_err"}, align_err, '0);
    chk({nm, "_all_aligned"}, all_aligned, 0);
    chk({nm, "_data_out_valid"}, data_out_valid, 0);
  endtask
  initial begin
    int k;
    bit found;
    for (int c = 0; c < CH; c++) begin
      off[c] = 0;
      never[c] = 0;
    end
    tbl[0] = '{1, 0, '1, '0}; tbl[1] = '{1, 0, '1, '0}; tbl[2] = '{1, 0, '1, '0};
    tbl[3] = '{1, 1, '1, '0}; tbl[4] = '{1, 0, '1, '0}; tbl[5] = '{1, 0, '1, '0};
    tbl[6] = '{1, 0, '1, '0}; tbl[7] = '{0, 0, '1, '0}; tbl[8] = '{1, 0, '0, '0};
    tbl[9] = '{1, 0, '0, '1}; tbl[10] = '{1, 1, '0, '0}; tbl[11] = '{1, 1, '0, '0};
    #12;
    outputs_zero("reset");
    chk("reset_data_out", data_out, '0);
    model_reset();
    @(negedge ref_clk);
    ref_rst = 0;
    off[3] = 3;
    never[5] = 1;
    en = 1;
    spc_on = 1;
    clear_counts();
    for (int i = 0; i < 250; i++) begin
      lane_tick();
      if (aligned[0] && first_al0 < 0) first_al0 = i + 1;
    end
    chk("lock_latency_ch0", 32'(first_al0), 17);
    chk("slips_ch3", 32'(nslip[3]), 3);
    chk("slips_ch5", 32'(nslip[5]), 7);
    for (int c = 0; c < CH; c++)
      if (c != 3 && c != 5) chk("slips_other", 32'(nslip[c]), 0);
    chk("err_ch5", align_err[5], 1);
    chk("aligned_ch3", aligned[3], 1);
    chk("all_aligned_fail", all_aligned, 0);
    clear_counts();
    pulse_realign();
    chk("realign_clears_err", align_err, '0);
    for (int i = 0; i < 100; i++) lane_tick();
    chk("reslips_ch5", 32'(nslip[5]), 7);
    chk("reerr_ch5", align_err[5], 1);
    never[5] = 0;
    off[5] = 5;
    pulse_realign();
    for (int i = 0; i < 100; i++) lane_tick();
    chk("all_locked", all_aligned, 1);
    chk("dv_locked", data_out_valid, 1);
    spc_on = 0;
    for (int i = 0; i < 12; i++) begin
      wv = tbl[i].wv;
      fw = tbl[i].hit ? {CH{FP}} : {CH{~FP}};
      dw = {$urandom, $urandom};
      tick();
      chk("tbl_aligned", aligned, tbl[i].al);
      chk("tbl_bitslip", bitslip, tbl[i].bs);
    end
    for (int i = 0; i < 60; i++) lane_tick();
    chk("relock_after_table", all_aligned, 1);
    off[2] = 2;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      lane_tick();
      found = bitslip[2];
    end
    chk("slip_before_reset", found, 1);
    lane_tick();
    lane_tick();
    #2 ref_rst = 1;
    #1;
    outputs_zero("async_reset");
    chk("async_reset_data_out", data_out, '0);
    model_reset();
    prev_bs = '0;
    @(negedge ref_clk);
    ref_rst = 0;
    for (int i = 0; i < 60; i++) lane_tick();
    chk("relock_after_reset", all_aligned, 1);
    off[4] = 3;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      lane_tick();
      found = bitslip[4];
    end
    chk("slip_before_disable", found, 1);
    lane_tick();
    en = 0;
    lane_tick();
    outputs_zero("disable");
    lane_tick();
    en = 1;
    gap_pct = 50;
    pulse_realign();
    for (int i = 0; i < 200; i++) lane_tick();
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) gap_pct = $urandom_range(0, 60);
      rl = $urandom_range(0, 99) == 0;
      if ($urandom_range(0, 199) == 0) en = ~en;
      if ($urandom_range(0, 49) == 0) begin
        k = $urandom_range(0, CH - 1);
        off[k] = $urandom_range(0, S - 1);
        never[k] = $urandom_range(0, 9) == 0;
      end
      lane_tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
